// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank.
package clk_div_pkg;

  localparam int unsigned CH_DEF   = 4;
  localparam int unsigned W_DEF    = 8;
  localparam int unsigned SYNC_DEF = 2;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: synchroniser, edge detect, counter, pending factor and mode latch.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned SYNC = SYNC_DEF
) (
  input  logic         Clk_Ref,
  input  logic         RST,
  input  logic         Clk_In,
  input  logic [W-1:0] Div_Fact,
  input  logic         Load,
  input  logic         Mode,
  input  logic         Enable,
  output logic         Clk_Out,
  output logic         Fact_Ack
);

  logic [SYNC-1:0] sync_q;
  logic            prev_q;
  logic            edge_q;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    fact_q, fact_d;
  logic [W-1:0]    pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            mode_q, mode_d;
  logic            out_d;
  logic            ack_d;
  logic            halted_c;
  logic            term_c;

  // Synchroniser chain followed by a registered rising-edge detector
  always_ff @(posedge Clk_Ref or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], Clk_In};
      prev_q <= sync_q[SYNC-1];
      edge_q <= sync_q[SYNC-1] & ~prev_q;
    end
  end

  assign halted_c = (fact_q == '0);
  assign term_c   = edge_q & Enable & ~halted_c & (cnt_q == fact_q - W'(1));

  // Counter, pending-factor and output next-state logic
  always_comb begin
    cnt_d      = cnt_q;
    fact_d     = fact_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    mode_d     = mode_q;
    out_d      = (mode_q == MODE_PULSE) ? 1'b0 : Clk_Out;
    ack_d      = 1'b0;
    if (halted_c) begin
      // A halted channel starts at once; the mode is latched at start so the
      // first terminal event already follows the requested mode.
      cnt_d = '0;
      out_d = 1'b0;
      if (Load) begin
        fact_d     = Div_Fact;
        mode_d     = Mode;
        ack_d      = 1'b1;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        fact_d     = pend_q;
        mode_d     = Mode;
        ack_d      = 1'b1;
        pend_vld_d = 1'b0;
      end
    end else begin
      if (Load) begin
        pend_d     = Div_Fact;
        pend_vld_d = 1'b1;
      end
      if (term_c) begin
        cnt_d  = '0;
        mode_d = Mode;
        if (Mode == MODE_TOGGLE) begin
          out_d = ~Clk_Out;
        end else begin
          // Entering pulse mode from toggle mode clears the output instead of pulsing.
          out_d = (mode_q == MODE_PULSE);
        end
        if (pend_vld_q) begin
          // The old pending value applies; a same-cycle Load stays pending.
          fact_d     = pend_q;
          ack_d      = 1'b1;
          pend_vld_d = Load;
          if (pend_q == '0) begin
            out_d = 1'b0;
          end
        end
      end else if (edge_q && Enable) begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Channel state registers
  always_ff @(posedge Clk_Ref or negedge RST) begin
    if (!RST) begin
      cnt_q      <= '0;
      fact_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      mode_q     <= MODE_TOGGLE;
      Clk_Out    <= 1'b0;
      Fact_Ack   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      fact_q     <= fact_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      mode_q     <= mode_d;
      Clk_Out    <= out_d;
      Fact_Ack   <= ack_d;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers clocked by a single reference clock.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned CH   = CH_DEF,
  parameter int unsigned W    = W_DEF,
  parameter int unsigned SYNC = SYNC_DEF
) (
  input  logic            Clk_Ref,
  input  logic            RST,
  input  logic [CH-1:0]   Clk_In,
  input  logic [CH*W-1:0] Div_Fact,
  input  logic [CH-1:0]   Load,
  input  logic [CH-1:0]   Mode,
  input  logic            Enable,
  output logic [CH-1:0]   Clk_Out,
  output logic [CH-1:0]   Fact_Ack
);

  // One divider channel per input clock
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    clk_div_chan #(
      .W    (W),
      .SYNC (SYNC)
    ) u_chan (
      .Clk_Ref  (Clk_Ref),
      .RST      (RST),
      .Clk_In   (Clk_In[gi]),
      .Div_Fact (Div_Fact[gi*W +: W]),
      .Load     (Load[gi]),
      .Mode     (Mode[gi]),
      .Enable   (Enable),
      .Clk_Out  (Clk_Out[gi]),
      .Fact_Ack (Fact_Ack[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: event-level reference model plus directed literal checks.
module tb_clk_div_bank;

  localparam int unsigned CH   = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned SYNC = 2;
  localparam int          FMAX = (1 << W) - 1;

  logic            Clk_Ref = 1'b0;
  logic            RST;
  logic [CH-1:0]   Clk_In;
  logic [CH*W-1:0] Div_Fact;
  logic [CH-1:0]   Load;
  logic [CH-1:0]   Mode;
  logic            Enable;
  logic [CH-1:0]   Clk_Out;
  logic [CH-1:0]   Fact_Ack;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 Clk_Ref = ~Clk_Ref;

  clk_div_bank #(.CH(CH), .W(W), .SYNC(SYNC)) dut (
    .Clk_Ref  (Clk_Ref),
    .RST      (RST),
    .Clk_In   (Clk_In),
    .Div_Fact (Div_Fact),
    .Load     (Load),
    .Mode     (Mode),
    .Enable   (Enable),
    .Clk_Out  (Clk_Out),
    .Fact_Ack (Fact_Ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: timeline of sampled inputs, factor counted with modulo arithmetic
  int               m_cnt  [CH];
  int               m_fact [CH];
  int               m_pend [CH];
  bit               m_pv   [CH];
  bit               m_mode [CH];
  bit               m_out  [CH];
  bit               m_ack  [CH];
  logic [SYNC+2:0]  m_hist [CH];

  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_fact[i] = 0; m_pend[i] = 0; m_pv[i] = 0;
      m_mode[i] = 0; m_out[i] = 0; m_ack[i] = 0; m_hist[i] = '0;
    end
  endtask

  initial begin
    bit ev, ld, md, nout;
    int fin;
    m_reset();
    forever begin
      @(posedge Clk_Ref or negedge RST);
      if (RST !== 1'b1) begin
        m_reset();
      end else begin
        for (int i = 0; i < CH; i++) begin
          m_hist[i] = {m_hist[i][SYNC+1:0], Clk_In[i]};
          // An input edge sampled at cycle n is acted on at cycle n+SYNC+1.
          ev  = m_hist[i][SYNC+1] & ~m_hist[i][SYNC+2];
          ld  = Load[i];
          md  = Mode[i];
          fin = int'(Div_Fact[i*W +: W]);
          m_ack[i] = 0;
          nout = m_mode[i] ? 1'b0 : m_out[i];
          if (m_fact[i] == 0) begin
            m_cnt[i] = 0;
            nout = 0;
            if (ld || m_pv[i]) begin
              m_fact[i] = ld ? fin : m_pend[i];
              m_mode[i] = md;
              m_ack[i]  = 1;
              m_pv[i]   = 0;
            end
          end else begin
            if (ev && Enable) begin
              m_cnt[i] = (m_cnt[i] + 1) % m_fact[i];
              if (m_cnt[i] == 0) begin
                nout = md ? m_mode[i] : !m_out[i];
                m_mode[i] = md;
                if (m_pv[i]) begin
                  m_fact[i] = m_pend[i];
                  m_ack[i]  = 1;
                  m_pv[i]   = 0;
                  if (m_fact[i] == 0) nout = 0;
                end
              end
            end
            if (ld) begin
              m_pend[i] = fin;
              m_pv[i]   = 1;
            end
          end
          m_out[i] = nout;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus activity counters for directed checks
  int            trans [CH];
  int            acks  [CH];
  int            highs [CH];
  logic [CH-1:0] prev_out = '0;

  initial begin
    logic [CH-1:0] e_out, e_ack;
    for (int i = 0; i < CH; i++) begin
      trans[i] = 0; acks[i] = 0; highs[i] = 0;
    end
    forever begin
      @(negedge Clk_Ref);
      for (int i = 0; i < CH; i++) begin
        e_out[i] = m_out[i];
        e_ack[i] = m_ack[i];
      end
      chk("clk_out_vs_model", 32'(Clk_Out), 32'(e_out));
      chk("fact_ack_vs_model", 32'(Fact_Ack), 32'(e_ack));
      for (int i = 0; i < CH; i++) begin
        if (Clk_Out[i] !== prev_out[i]) trans[i]++;
        if (Fact_Ack[i] === 1'b1) acks[i]++;
        if (Clk_Out[i] === 1'b1) highs[i]++;
      end
      prev_out = Clk_Out;
    end
  end

  task automatic tick();
    @(negedge Clk_Ref);
    #1;
  endtask

  task automatic do_load(input int ch, input int f, input bit md);
    tick();
    Load[ch] = 1'b1;
    Div_Fact[ch*W +: W] = W'(f);
    Mode[ch] = md;
    tick();
    Load[ch] = 1'b0;
  endtask

  task automatic in_edges(input logic [CH-1:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      Clk_In = Clk_In | m;
      repeat (3) tick();
      Clk_In = Clk_In & ~m;
      repeat (2) tick();
    end
  endtask

  // One input edge on channel ch, sampling Clk_Out SYNC, SYNC+1 and SYNC+2 cycles after it is seen
  task automatic edge_probe(input int ch, output logic o3, output logic o4, output logic o5);
    logic [CH-1:0] m;
    m = CH'(1) << ch;
    tick();
    Clk_In = Clk_In | m;
    repeat (3) tick();
    o3 = Clk_Out[ch];
    Clk_In = Clk_In & ~m;
    tick();
    o4 = Clk_Out[ch];
    tick();
    o5 = Clk_Out[ch];
  endtask

  function automatic int rand_fact();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 9) return FMAX;
    return int'($urandom_range(1, 6));
  endfunction

  initial begin
    logic o3, o4, o5;
    int t0, a0, h0, s0;
    RST = 1'b0; Clk_In = '0; Div_Fact = '0; Load = '0; Mode = '0; Enable = 1'b1;
    repeat (3) tick();
    chk("reset_clk_out", 32'(Clk_Out), 32'h0);
    chk("reset_fact_ack", 32'(Fact_Ack), 32'h0);
    RST = 1'b1;
    tick();

    // ch0: F=3 toggle, 12 edges
    a0 = acks[0]; t0 = trans[0];
    do_load(0, 3, 1'b0);
    chk("ack_after_halted_load", 32'(Fact_Ack[0]), 32'h1);
    in_edges(4'h1, 2);
    edge_probe(0, o3, o4, o5);
    chk("latency_before", 32'(o3), 32'h0);
    chk("latency_toggle", 32'(o4), 32'h1);
    in_edges(4'h1, 9);
    chk("f3_toggle_count", 32'(trans[0] - t0), 32'd4);
    chk("f3_final_level", 32'(Clk_Out[0]), 32'h0);
    chk("f3_ack_count", 32'(acks[0] - a0), 32'd1);

    // ch1: F=4 pulse, 8 edges
    h0 = highs[1];
    do_load(1, 4, 1'b1);
    in_edges(4'h2, 3);
    edge_probe(1, o3, o4, o5);
    chk("pulse_before", 32'(o3), 32'h0);
    chk("pulse_high", 32'(o4), 32'h1);
    chk("pulse_one_cycle", 32'(o5), 32'h0);
    in_edges(4'h2, 4);
    chk("pulse_count", 32'(highs[1] - h0), 32'd2);

    // ch0: reload F=5 while running, after edge 1
    t0 = trans[0]; a0 = acks[0];
    in_edges(4'h1, 1);
    do_load(0, 5, 1'b0);
    chk("no_ack_while_pending", 32'(Fact_Ack[0]), 32'h0);
    in_edges(4'h1, 2);
    chk("reload_ack_at_edge3", 32'(acks[0] - a0), 32'd1);
    chk("reload_toggle_edge3", 32'(trans[0] - t0), 32'd1);
    in_edges(4'h1, 4);
    chk("reload_hold_to_edge7", 32'(trans[0] - t0), 32'd1);
    in_edges(4'h1, 1);
    chk("reload_toggle_edge8", 32'(trans[0] - t0), 32'd2);

    // ch0: Enable low mid-count freezes the counter
    t0 = trans[0];
    in_edges(4'h1, 2);
    Enable = 1'b0;
    in_edges(4'h1, 4);
    chk("enable_low_frozen", 32'(trans[0] - t0), 32'd0);
    Enable = 1'b1;
    in_edges(4'h1, 2);
    chk("enable_resume_hold", 32'(trans[0] - t0), 32'd0);
    in_edges(4'h1, 1);
    chk("enable_resume_wrap", 32'(trans[0] - t0), 32'd1);

    // ch2: F=1 toggles every edge; ch3: F=0 stays low
    t0 = trans[2];
    do_load(2, 1, 1'b0);
    in_edges(4'h4, 4);
    chk("f1_toggle_count", 32'(trans[2] - t0), 32'd4);
    do_load(3, 0, 1'b0);
    chk("f0_load_ack", 32'(Fact_Ack[3]), 32'h1);
    in_edges(4'h8, 4);
    chk("f0_no_activity", 32'(trans[3]), 32'd0);
    chk("f0_level", 32'(Clk_Out[3]), 32'h0);

    // Asynchronous reset mid-period
    in_edges(4'h4, 1);
    chk("pre_reset_high", 32'(Clk_Out[2]), 32'h1);
    tick();
    #2 RST = 1'b0;
    #1;
    chk("async_reset_clk_out", 32'(Clk_Out), 32'h0);
    chk("async_reset_ack", 32'(Fact_Ack), 32'h0);
    tick(); tick();
    RST = 1'b1;
    s0 = trans[0] + trans[1] + trans[2] + trans[3];
    in_edges(4'hF, 4);
    chk("halted_after_reset", 32'(Clk_Out), 32'h0);
    chk("halted_no_toggles", 32'(trans[0] + trans[1] + trans[2] + trans[3] - s0), 32'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 2) == 0) Clk_In[i] = ~Clk_In[i];
        Load[i] = ($urandom_range(0, 15) == 0);
        if (Load[i]) Div_Fact[i*W +: W] = W'(rand_fact());
        if ($urandom_range(0, 7) == 0) Mode[i] = ~Mode[i];
      end
      Enable = ($urandom_range(0, 9) != 0);
      if (c == 1500) begin
        #2 RST = 1'b0;
        #1;
        chk("rand_async_reset", 32'({Clk_Out, Fact_Ack}), 32'h0);
        repeat (3) tick();
        RST = 1'b1;
      end
    end
    Load = '0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
